// File: rtl/riscv_pkg.sv
// Shared RV32 encodings and store-path types for the load/store units.
// Also holds the lane-alignment helpers used by store_unit.
package riscv_pkg;

    localparam logic [6:0] OPC_STORE    = 7'b0100011;

    localparam logic [2:0] F3_SB        = 3'b000;
    localparam logic [2:0] F3_SH        = 3'b001;
    localparam logic [2:0] F3_SW        = 3'b010;

    localparam logic [1:0] STAGE_FETCH  = 2'd0;
    localparam logic [1:0] STAGE_DECODE = 2'd1;
    localparam logic [1:0] STAGE_EXEC   = 2'd2;
    localparam logic [1:0] STAGE_WB     = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } store_entry_t;

    // Illegal funct3 is folded into the fault so the caller has one drop condition.
    function automatic logic store_fault_check(input logic [2:0] f3, input logic [1:0] off);
        logic flt;
        case (f3)
            F3_SB:   flt = 1'b0;
            F3_SH:   flt = off[0];
            F3_SW:   flt = (off != 2'b00);
            default: flt = 1'b1;
        endcase
        return flt;
    endfunction

    function automatic store_entry_t lane_entry(input logic [2:0] f3, input logic [31:0] ea,
                                                input logic [31:0] rs2);
        store_entry_t e;
        e.addr = {ea[31:2], 2'b00};
        case (f3)
            F3_SB: begin
                e.wdata = {4{rs2[7:0]}};
                e.wstrb = 4'b0001 << ea[1:0];
            end
            F3_SH: begin
                e.wdata = {2{rs2[15:0]}};
                e.wstrb = 4'b0011 << ea[1:0];
            end
            default: begin
                e.wdata = rs2;
                e.wstrb = 4'b1111;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Store buffer: DEPTH-entry FIFO of lane-aligned writes.
// Pointers carry a wrap bit so full and empty are distinguishable without a counter.
module store_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  store_entry_t             push_data,
    input  logic                     pop,
    output store_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    store_entry_t mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;

    // Pointer update; a simultaneous push and pop advances both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage needs no reset; the pointers define which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/store_unit.sv
// RV32 store unit: accepts SB/SH/SW in stage 2, lane-aligns them into a store buffer
// and drains the buffer to data memory over a req/ack handshake.
module store_unit
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [1:0]        stage,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [31:0]       bus_rs1,
    input  logic [31:0]       bus_rs2,
    input  logic [31:0]       immediate,
    output logic              stall,
    output logic              store_fault,
    output logic              buffer_empty,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack
);

    logic [1:0]              prev_stage_r;
    logic                    stall_pend_r;
    logic                    store_fault_r;
    logic                    mem_req_r;
    logic [ADDR_W-1:0]       mem_addr_r;
    logic [31:0]             mem_wdata_r;
    logic [3:0]              mem_wstrb_r;

    logic                    store_hit_s;
    logic                    fault_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    stall_s;
    logic                    load_s;
    logic [31:0]             ea_s;
    store_entry_t            entry_s;
    store_entry_t            head_s;
    store_entry_t            load_entry_s;
    logic                    full_s;
    logic                    empty_s;
    logic [$clog2(DEPTH):0]  count_s;

    // A stalled store keeps stage at 2, so the retry flag re-arms the edge detect.
    assign store_hit_s = (stage == STAGE_EXEC) && (opcode == OPC_STORE) &&
                         ((prev_stage_r != STAGE_EXEC) || stall_pend_r);
    assign ea_s        = bus_rs1 + immediate;
    assign entry_s     = lane_entry(funct3, ea_s, bus_rs2);
    assign fault_s     = store_fault_check(funct3, ea_s[1:0]);

    assign pop_s       = mem_req_r && mem_ack;
    assign push_s      = store_hit_s && !fault_s && (!full_s || pop_s);
    assign stall_s     = store_hit_s && !fault_s && full_s && !pop_s;

    // With an empty buffer the incoming store bypasses straight onto the bus registers,
    // but it is still pushed so the ack pop stays uniform.
    assign load_s       = !mem_req_r && (!empty_s || push_s);
    assign load_entry_s = empty_s ? entry_s : head_s;

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (Reset),
        .push      (push_s),
        .push_data (entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Accept edge-detect, fault pulse and memory-side request registers.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            prev_stage_r  <= STAGE_FETCH;
            stall_pend_r  <= 1'b0;
            store_fault_r <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= 32'h0000_0000;
            mem_wstrb_r   <= 4'b0000;
        end else begin
            prev_stage_r  <= stage;
            stall_pend_r  <= stall_s;
            store_fault_r <= store_hit_s && fault_s;
            if (pop_s) begin
                mem_req_r   <= 1'b0;
            end else if (load_s) begin
                mem_req_r   <= 1'b1;
                mem_addr_r  <= load_entry_s.addr[ADDR_W-1:0];
                mem_wdata_r <= load_entry_s.wdata;
                mem_wstrb_r <= load_entry_s.wstrb;
            end else begin
                mem_req_r   <= mem_req_r;
            end
        end
    end

    assign stall        = stall_s;
    assign store_fault  = store_fault_r;
    assign buffer_empty = (count_s == '0) && !mem_req_r;
    assign mem_req      = mem_req_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign mem_wstrb    = mem_wstrb_r;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: reset, lane alignment, faults, back-pressure and
// reset during a pending handshake, with hand-computed expected values.
module tb_store_unit;
    import riscv_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [1:0]  stage;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] bus_rs1;
    logic [31:0] bus_rs2;
    logic [31:0] immediate;
    logic        stall;
    logic        store_fault;
    logic        buffer_empty;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;

    int nchecks = 0;
    int nerrors = 0;

    always #5 CLK = ~CLK;

    store_unit #(.DEPTH(4), .ADDR_W(32)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .stage        (stage),
        .opcode       (opcode),
        .funct3       (funct3),
        .bus_rs1      (bus_rs1),
        .bus_rs2      (bus_rs2),
        .immediate    (immediate),
        .stall        (stall),
        .store_fault  (store_fault),
        .buffer_empty (buffer_empty),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One cycle in stage 2 with a store, then leave stage 2.
    task automatic issue(input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] imm, input logic [31:0] rs2);
        stage     = STAGE_EXEC;
        opcode    = OPC_STORE;
        funct3    = f3;
        bus_rs1   = rs1;
        immediate = imm;
        bus_rs2   = rs2;
        #1;
        chk("stall_on_issue", {31'd0, stall}, 32'd0);
        step();
        stage = STAGE_WB;
    endtask

    initial begin
        Reset     = 1'b0;
        stage     = STAGE_WB;
        opcode    = 7'd0;
        funct3    = 3'd0;
        bus_rs1   = 32'd0;
        bus_rs2   = 32'd0;
        immediate = 32'd0;
        mem_ack   = 1'b0;

        // 1: reset state
        step();
        step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_empty", {31'd0, buffer_empty}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_fault", {31'd0, store_fault}, 32'd0);
        Reset = 1'b1;
        step();

        // 2: SW with ack held high
        mem_ack = 1'b1;
        issue(F3_SW, 32'h0000_0100, 32'h0000_0008, 32'hDEAD_BEEF);
        chk("sw_req", {31'd0, mem_req}, 32'd1);
        chk("sw_addr", mem_addr, 32'h0000_0108);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sw_wstrb", {28'd0, mem_wstrb}, 32'h0000_000F);
        chk("sw_busy", {31'd0, buffer_empty}, 32'd0);
        step();
        chk("sw_popped_req", {31'd0, mem_req}, 32'd0);
        chk("sw_popped_empty", {31'd0, buffer_empty}, 32'd1);

        // 3: SB then SH into the same word, drained in order
        mem_ack = 1'b0;
        issue(F3_SB, 32'h0000_0203, 32'h0000_0000, 32'h0000_005A);
        chk("sb_req", {31'd0, mem_req}, 32'd1);
        chk("sb_addr", mem_addr, 32'h0000_0200);
        chk("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
        chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h0000_0008);
        step();
        issue(F3_SH, 32'h0000_0202, 32'h0000_0000, 32'h0000_1234);
        chk("sb_stable_wdata", mem_wdata, 32'h5A5A_5A5A);
        chk("sb_stable_wstrb", {28'd0, mem_wstrb}, 32'h0000_0008);
        mem_ack = 1'b1;
        step();
        chk("sb_pop_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("sh_req", {31'd0, mem_req}, 32'd1);
        chk("sh_addr", mem_addr, 32'h0000_0200);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        chk("sh_wstrb", {28'd0, mem_wstrb}, 32'h0000_000C);
        step();
        chk("sh_done_empty", {31'd0, buffer_empty}, 32'd1);
        mem_ack = 1'b0;

        // 4: misaligned SH and illegal funct3
        issue(F3_SH, 32'h0000_0101, 32'h0000_0000, 32'h0000_BEEF);
        chk("mis_fault", {31'd0, store_fault}, 32'd1);
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        chk("mis_empty", {31'd0, buffer_empty}, 32'd1);
        step();
        chk("mis_fault_pulse", {31'd0, store_fault}, 32'd0);
        issue(3'b011, 32'h0000_0100, 32'h0000_0000, 32'h0000_0001);
        chk("ill_fault", {31'd0, store_fault}, 32'd1);
        chk("ill_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("ill_fault_pulse", {31'd0, store_fault}, 32'd0);
        chk("ill_empty", {31'd0, buffer_empty}, 32'd1);

        // 5: fill the buffer with ack low, fifth store stalls
        for (int i = 0; i < 4; i++) begin
            issue(F3_SW, 32'h0000_0400 + 32'(4 * i), 32'h0000_0000, 32'hA000_0000 + 32'(i));
            step();
        end
        stage     = STAGE_EXEC;
        opcode    = OPC_STORE;
        funct3    = F3_SW;
        bus_rs1   = 32'h0000_0410;
        immediate = 32'h0000_0000;
        bus_rs2   = 32'hA000_0004;
        #1;
        chk("full_stall", {31'd0, stall}, 32'd1);
        step();
        chk("full_stall_hold", {31'd0, stall}, 32'd1);
        chk("wait_req", {31'd0, mem_req}, 32'd1);
        chk("wait_addr", mem_addr, 32'h0000_0400);
        chk("wait_wdata", mem_wdata, 32'hA000_0000);
        step();
        chk("full_stall_hold2", {31'd0, stall}, 32'd1);
        chk("wait_addr2", mem_addr, 32'h0000_0400);
        mem_ack = 1'b1;
        #1;
        chk("stall_clears_on_ack", {31'd0, stall}, 32'd0);
        step();
        stage = STAGE_WB;
        chk("drain0_pop", {31'd0, mem_req}, 32'd0);
        for (int k = 1; k < 5; k++) begin
            step();
            chk("drain_req", {31'd0, mem_req}, 32'd1);
            chk("drain_addr", mem_addr, 32'h0000_0400 + 32'(4 * k));
            chk("drain_wdata", mem_wdata, 32'hA000_0000 + 32'(k));
            chk("drain_wstrb", {28'd0, mem_wstrb}, 32'h0000_000F);
            step();
        end
        chk("drain_empty", {31'd0, buffer_empty}, 32'd1);
        mem_ack = 1'b0;

        // 6: reset during a pending handshake, then stage held at 2
        for (int i = 0; i < 3; i++) begin
            issue(F3_SW, 32'h0000_0800 + 32'(4 * i), 32'h0000_0000, 32'h0000_0077);
            step();
        end
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        chk("pre_rst_busy", {31'd0, buffer_empty}, 32'd0);
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_empty", {31'd0, buffer_empty}, 32'd1);
        chk("mid_rst_addr", mem_addr, 32'h0000_0000);
        stage     = STAGE_EXEC;
        opcode    = OPC_STORE;
        funct3    = F3_SW;
        bus_rs1   = 32'h0000_0900;
        immediate = 32'h0000_0000;
        bus_rs2   = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        stage = STAGE_WB;
        chk("hold_req", {31'd0, mem_req}, 32'd1);
        chk("hold_addr", mem_addr, 32'h0000_0900);
        chk("hold_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_ack = 1'b1;
        step();
        chk("hold_one_push", {31'd0, buffer_empty}, 32'd1);
        mem_ack = 1'b0;
        step();
        chk("hold_no_reload", {31'd0, mem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
